// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the n-way demultiplexing buffer.
package dmux_pkg;

    localparam int ERR_CNT_W   = 8;
    localparam int ERR_CNT_MAX = (1 << ERR_CNT_W) - 1;

    // A single channel still needs a one-bit select so the port never collapses to zero width.
    function automatic int sel_width(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/dmux_nway_buf_if.sv
// Upstream word port and per-channel downstream ports of the n-way demultiplexing buffer.
interface dmux_nway_buf_if
    import dmux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int DW   = 8
);
    localparam int SEL_W = sel_width(N_CH);

    logic [DW-1:0]             in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_bcast;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_CH-1:0][DW-1:0]   out_data;
    logic [N_CH-1:0]           out_valid;
    logic [N_CH-1:0]           out_ready;
    logic                      err_sel;
    logic [ERR_CNT_W-1:0]      err_cnt;

    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, err_sel, err_cnt
    );

    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, err_sel, err_cnt
    );

endinterface

// File: rtl/dmux_slot.sv
// One-entry holding slot for a single output channel; accepts a load in the same cycle it drains.
module dmux_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          drain,
    output logic          free,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // Data is kept after draining so the idle value stays deterministic.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign free  = !valid_q || drain;
    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/dmux_nway_buf.sv
// N-way demultiplexer with a one-word buffer per channel, all-or-nothing broadcast and drop counting.
module dmux_nway_buf
    import dmux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int DW   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dmux_nway_buf_if.slave    bus
);

    localparam int               SEL_W    = sel_width(N_CH);
    localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W + 1)'(N_CH);

    logic [N_CH-1:0]           slot_free;
    logic [N_CH-1:0]           slot_load;
    logic [N_CH-1:0]           slot_valid;
    logic [N_CH-1:0][DW-1:0]   slot_data;

    logic                      in_range;
    logic                      sel_free;
    logic                      in_ready;
    logic                      xfer;
    logic                      drop;

    logic                      err_sel_q, err_sel_d;
    logic [ERR_CNT_W-1:0]      err_cnt_q, err_cnt_d;

    // Out-of-range selects are always accepted and discarded so they never stall upstream.
    always_comb begin
        in_range  = {1'b0, bus.in_sel} < N_CH_EXT;
        sel_free  = 1'b0;
        slot_load = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.in_sel == SEL_W'(i)) begin
                sel_free = slot_free[i];
            end
        end
        if (!rst_n) begin
            in_ready = 1'b0;
        end else if (bus.in_bcast) begin
            in_ready = &slot_free;
        end else if (!in_range) begin
            in_ready = 1'b1;
        end else begin
            in_ready = sel_free;
        end
        xfer = bus.in_valid && in_ready;
        drop = xfer && !bus.in_bcast && !in_range;
        for (int i = 0; i < N_CH; i++) begin
            slot_load[i] = xfer && (bus.in_bcast || bus.in_sel == SEL_W'(i));
        end
    end

    always_comb begin
        err_sel_d = drop;
        err_cnt_d = err_cnt_q;
        if (drop && err_cnt_q != ERR_CNT_W'(ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sel_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_sel_q <= err_sel_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        dmux_slot #(
            .DW(DW)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (slot_load[g]),
            .load_data (bus.in_data),
            .drain     (bus.out_ready[g]),
            .free      (slot_free[g]),
            .valid     (slot_valid[g]),
            .data      (slot_data[g])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = slot_valid;
    assign bus.out_data  = slot_data;
    assign bus.err_sel   = err_sel_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dmux_nway_buf.sv
// Self-checking bench: directed scenarios plus random traffic on a 3-channel buffer against a slot-level model,
// and a streaming check on 4-channel and 1-channel instances.
module tb_dmux_nway_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] m_data [3];
    bit         m_valid [3];
    int         m_err_cnt;
    bit         m_err_sel;

    always #5 clk = ~clk;

    dmux_nway_buf_if #(.N_CH(3), .DW(8)) bus ();
    dmux_nway_buf_if #(.N_CH(4), .DW(8)) bus4 ();
    dmux_nway_buf_if #(.N_CH(1), .DW(8)) bus1 ();

    dmux_nway_buf #(.N_CH(3), .DW(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    dmux_nway_buf #(.N_CH(4), .DW(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    dmux_nway_buf #(.N_CH(1), .DW(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of traffic on the 3-channel instance: drive, check readiness, clock, update model, check outputs.
    task automatic applyStimulus(input bit rst, input int sel, input bit bcast, input bit valid,
                                 input logic [7:0] data, input logic [2:0] ready);
        bit         exp_ready;
        bit         all_free;
        bit         xfer;
        logic [2:0] exp_valid;
        rst_n         = rst;
        bus.in_sel    = 2'(sel);
        bus.in_bcast  = bcast;
        bus.in_valid  = valid;
        bus.in_data   = data;
        bus.out_ready = ready;
        #1;
        all_free = 1'b1;
        for (int i = 0; i < 3; i++) if (m_valid[i] && !ready[i]) all_free = 1'b0;
        if (!rst)          exp_ready = 1'b0;
        else if (bcast)    exp_ready = all_free;
        else if (sel >= 3) exp_ready = 1'b1;
        else               exp_ready = !m_valid[sel] || ready[sel];
        checkOutput("in_ready", bus.in_ready, exp_ready);
        xfer = valid && exp_ready;
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_valid[i] = 1'b0;
                m_data[i]  = 8'h00;
            end
            m_err_cnt = 0;
            m_err_sel = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (xfer && (bcast || sel == i)) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = data;
                end else if (ready[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            m_err_sel = xfer && !bcast && sel >= 3;
            if (m_err_sel && m_err_cnt < 255) m_err_cnt++;
        end
        for (int i = 0; i < 3; i++) exp_valid[i] = m_valid[i];
        checkOutput("out_valid", bus.out_valid, exp_valid);
        for (int i = 0; i < 3; i++) checkOutput($sformatf("out_data[%0d]", i), bus.out_data[i], m_data[i]);
        checkOutput("err_sel", bus.err_sel, m_err_sel);
        checkOutput("err_cnt", bus.err_cnt, m_err_cnt);
    endtask

    initial begin
        bus.in_data = '0;  bus.in_sel = '0;  bus.in_bcast = 1'b0;  bus.in_valid = 1'b0;  bus.out_ready = '0;
        bus4.in_data = '0; bus4.in_sel = '0; bus4.in_bcast = 1'b0; bus4.in_valid = 1'b0; bus4.out_ready = '1;
        bus1.in_data = '0; bus1.in_sel = '0; bus1.in_bcast = 1'b0; bus1.in_valid = 1'b0; bus1.out_ready = '1;
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = 8'h00;
        end
        m_err_cnt = 0;
        m_err_sel = 1'b0;

        $display("[TB] reset");
        applyStimulus(0, 0, 0, 1, 8'hFF, 3'b111);
        applyStimulus(0, 0, 0, 1, 8'hFF, 3'b111);
        checkOutput("reset_err_cnt4", bus4.err_cnt, 0);

        $display("[TB] unicast sweep");
        applyStimulus(1, 0, 0, 1, 8'hA0, 3'b111);
        applyStimulus(1, 1, 0, 1, 8'hA1, 3'b111);
        checkOutput("sweep_ch0", bus.out_data[0], 8'hA0);
        applyStimulus(1, 2, 0, 1, 8'hA2, 3'b111);
        checkOutput("sweep_ch2", bus.out_data[2], 8'hA2);
        applyStimulus(1, 0, 0, 0, 8'h00, 3'b111);

        $display("[TB] backpressure");
        applyStimulus(1, 1, 0, 1, 8'h11, 3'b101);
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0, 1, 8'h22, 3'b101);
        checkOutput("bp_hold", bus.out_data[1], 8'h11);
        applyStimulus(1, 1, 0, 1, 8'h22, 3'b111);
        checkOutput("bp_next", bus.out_data[1], 8'h22);
        applyStimulus(1, 0, 0, 0, 8'h00, 3'b111);

        $display("[TB] broadcast");
        applyStimulus(1, 2, 0, 1, 8'h77, 3'b011);
        applyStimulus(1, 0, 1, 1, 8'h5C, 3'b011);
        applyStimulus(1, 0, 1, 1, 8'h5C, 3'b011);
        applyStimulus(1, 0, 1, 1, 8'h5C, 3'b111);
        checkOutput("bcast_all", bus.out_valid, 3'b111);
        applyStimulus(1, 0, 0, 0, 8'h00, 3'b111);

        $display("[TB] out-of-range");
        for (int k = 0; k < 260; k++) applyStimulus(1, 3, 0, 1, 8'(k), 3'b111);
        checkOutput("err_saturate", bus.err_cnt, 8'd255);
        applyStimulus(1, 0, 0, 0, 8'h00, 3'b111);

        $display("[TB] reset mid-flight");
        applyStimulus(1, 0, 1, 1, 8'h3E, 3'b000);
        applyStimulus(0, 0, 1, 1, 8'h44, 3'b000);
        checkOutput("midrst_valid", bus.out_valid, 3'b000);
        applyStimulus(1, 1, 0, 1, 8'h55, 3'b000);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 63) != 0, $urandom_range(0, 3), $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom));
        end
        applyStimulus(1, 0, 0, 0, 8'h00, 3'b111);

        $display("[TB] streaming on 4 and 1 channel instances");
        for (int k = 0; k < 20; k++) begin
            bus4.in_sel   = 2'(k % 4);
            bus4.in_data  = 8'(k + 'h30);
            bus4.in_valid = 1'b1;
            bus1.in_sel   = 1'b0;
            bus1.in_data  = 8'(k + 'h60);
            bus1.in_valid = 1'b1;
            #1;
            checkOutput("n4_in_ready", bus4.in_ready, 1'b1);
            checkOutput("n1_in_ready", bus1.in_ready, 1'b1);
            @(posedge clk);
            #1;
            checkOutput("n4_valid", bus4.out_valid[k % 4], 1'b1);
            checkOutput("n4_data", bus4.out_data[k % 4], 8'(k + 'h30));
            checkOutput("n1_valid", bus1.out_valid[0], 1'b1);
            checkOutput("n1_data", bus1.out_data[0], 8'(k + 'h60));
            checkOutput("n4_err_sel", bus4.err_sel, 1'b0);
            checkOutput("n1_err_sel", bus1.err_sel, 1'b0);
        end
        bus4.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("n4_err_cnt", bus4.err_cnt, 0);
        checkOutput("n1_err_cnt", bus1.err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
